// File: rtl/width_packer_buffer.sv
// Packs narrow input chunks LSB-first into wide output words, with a flush
// path that emits a zero-padded partial word and a single held output register.
module width_packer_buffer #(
  parameter int input_width  = 4,
  parameter int output_width = 32
) (
  input  logic                                            clock,
  input  logic                                            nreset,
  input  logic                                            data_in_valid,
  input  logic [input_width-1:0]                          data_in,
  output logic                                            data_in_ready,
  input  logic                                            flush,
  output logic                                            data_out_valid,
  output logic [output_width-1:0]                         data_out,
  output logic [$clog2(output_width / input_width):0]     data_out_count,
  input  logic                                            data_out_ready
);

  localparam int ratio      = output_width / input_width;
  localparam int countWidth = $clog2(ratio) + 1;
  localparam logic [countWidth-1:0] lastIndex = countWidth'(ratio - 1);
  localparam logic [countWidth-1:0] fullCount = countWidth'(ratio);

  if ((output_width % input_width) != 0 || ratio < 2) begin : gBadWidths
    $error("width_packer_buffer: output_width must be a multiple of input_width with ratio >= 2");
  end

  logic [output_width-1:0] acc_q, acc_d;
  logic [countWidth-1:0]   fill_q, fill_d;
  logic                    pend_q, pend_d;
  logic [output_width-1:0] outData_q, outData_d;
  logic [countWidth-1:0]   outCount_q, outCount_d;
  logic                    outValid_q, outValid_d;

  logic                    outFree;
  logic                    inReady;
  logic                    accept;
  logic [output_width-1:0] packedWord;
  logic [countWidth-1:0]   filled;

  // The accumulator is always zero above the fill point, so partial words
  // leave the buffer already zero-padded.
  always_comb begin
    outFree    = !outValid_q || data_out_ready;
    inReady    = !pend_q && !((fill_q == lastIndex) && !outFree);
    accept     = data_in_valid && inReady;
    packedWord = acc_q;
    if (accept) begin
      packedWord[int'(fill_q)*input_width +: input_width] = data_in;
    end
    filled     = accept ? (fill_q + countWidth'(1)) : fill_q;

    acc_d      = packedWord;
    fill_d     = filled;
    pend_d     = pend_q;
    outData_d  = outData_q;
    outCount_d = outCount_q;
    outValid_d = outValid_q && !data_out_ready;

    if (accept && (fill_q == lastIndex)) begin
      // A flush arriving with the last chunk finds an empty word afterwards,
      // so it is satisfied by this single full word.
      outData_d  = packedWord;
      outCount_d = fullCount;
      outValid_d = 1'b1;
      acc_d      = '0;
      fill_d     = '0;
      pend_d     = 1'b0;
    end else if (pend_q || flush) begin
      if (filled == '0) begin
        pend_d = 1'b0;
      end else if (outFree) begin
        outData_d  = packedWord;
        outCount_d = filled;
        outValid_d = 1'b1;
        acc_d      = '0;
        fill_d     = '0;
        pend_d     = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      acc_q      <= '0;
      fill_q     <= '0;
      pend_q     <= 1'b0;
      outData_q  <= '0;
      outCount_q <= '0;
      outValid_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      pend_q     <= pend_d;
      outData_q  <= outData_d;
      outCount_q <= outCount_d;
      outValid_q <= outValid_d;
    end
  end

  assign data_in_ready  = inReady;
  assign data_out_valid = outValid_q;
  assign data_out       = outData_q;
  assign data_out_count = outCount_q;

endmodule

// File: tb/tb_width_packer_buffer.sv
// Scoreboard bench for width_packer_buffer: a chunk-list model turns observed
// input handshakes and flushes into expected words; a monitor checks outputs.
module tb_width_packer_buffer;

  localparam int InW   = 4;
  localparam int OutW  = 32;
  localparam int Ratio = OutW / InW;
  localparam int CntW  = $clog2(Ratio) + 1;

  logic            clock = 1'b0;
  logic            nreset = 1'b0;
  logic            data_in_valid = 1'b0;
  logic [InW-1:0]  data_in = '0;
  logic            data_in_ready;
  logic            flush = 1'b0;
  logic            data_out_valid;
  logic [OutW-1:0] data_out;
  logic [CntW-1:0] data_out_count;
  logic            data_out_ready = 1'b0;

  typedef struct packed {
    logic [OutW-1:0] data;
    logic [CntW-1:0] count;
  } word_t;

  word_t          expQ[$];
  logic [InW-1:0] chunkQ[$];
  int             checks = 0;
  int             errors = 0;

  width_packer_buffer #(.input_width(InW), .output_width(OutW)) dut (
    .clock         (clock),
    .nreset        (nreset),
    .data_in_valid (data_in_valid),
    .data_in       (data_in),
    .data_in_ready (data_in_ready),
    .flush         (flush),
    .data_out_valid(data_out_valid),
    .data_out      (data_out),
    .data_out_count(data_out_count),
    .data_out_ready(data_out_ready)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // A word is simply the pending chunks laid end to end from bit 0 upward.
  function automatic void emitWord();
    word_t w;
    w.data = '0;
    foreach (chunkQ[i]) w.data = w.data | (OutW'(chunkQ[i]) << (InW * i));
    w.count = CntW'(chunkQ.size());
    expQ.push_back(w);
    chunkQ.delete();
  endfunction

  // Reference model: sampled just before each rising edge.
  always @(negedge clock) begin
    #4;
    if (!nreset) begin
      chunkQ.delete();
      expQ.delete();
    end else begin
      if (data_in_valid && data_in_ready) begin
        chunkQ.push_back(data_in);
        if (chunkQ.size() == Ratio) emitWord();
      end
      if (flush && chunkQ.size() > 0) emitWord();
    end
  end

  // Monitor: a presented word must match the queue head every cycle it is held.
  always @(negedge clock) begin
    #4;
    if (nreset && data_out_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got 0x%08h count %0d, expected no word", data_out, data_out_count);
      end else begin
        checkOutput("word_data", data_out, expQ[0].data);
        checkOutput("word_count", 32'(data_out_count), 32'(expQ[0].count));
        if (data_out_ready) void'(expQ.pop_front());
      end
    end
  end

  // Offer one chunk until accepted; flush (if set) is only held for the first cycle.
  task automatic applyStimulus(input logic [InW-1:0] chunk, input logic withFlush, output int waited);
    bit done = 0;
    waited = 0;
    data_in_valid = 1'b1;
    data_in = chunk;
    flush = withFlush;
    while (!done && waited < 100) begin
      #4;
      if (data_in_ready) done = 1;
      else waited++;
      @(negedge clock);
      flush = 1'b0;
    end
    data_in_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 32'(waited), 32'(0));
  endtask

  task automatic applyFlush();
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
  endtask

  task automatic sendChunks(input int n, input string name);
    int waited;
    for (int i = 0; i < n; i++) begin
      applyStimulus(4'($urandom), 1'b0, waited);
      checkOutput(name, 32'(waited), 32'(0));
    end
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (expQ.size() != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, 32'(expQ.size()), 32'(0));
  endtask

  task automatic waitValid(input string name);
    bit seen = 0;
    int n = 0;
    while (!seen && n < 20) begin
      #4;
      if (data_out_valid) seen = 1;
      else begin
        n++;
        @(negedge clock);
      end
    end
    checkOutput(name, 32'(seen), 32'(1));
  endtask

  task automatic checkResetState(input string tag);
    #4;
    checkOutput({tag, "_valid"}, 32'(data_out_valid), 32'(0));
    checkOutput({tag, "_data"}, data_out, 32'h0);
    checkOutput({tag, "_count"}, 32'(data_out_count), 32'(0));
    checkOutput({tag, "_in_ready"}, 32'(data_in_ready), 32'(1));
    @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    repeat (3) @(negedge clock);
    nreset = 1'b1;
    checkResetState("reset");

    // Streaming with the sink always ready: no stalls at word boundaries.
    data_out_ready = 1'b1;
    sendChunks(32, "stream_no_stall");
    waitDrain("stream_drain");

    // Backpressure: 15 chunks fit (one held word + seven buffered), the 16th stalls.
    data_out_ready = 1'b0;
    sendChunks(15, "bp_accept");
    data_in_valid = 1'b1;
    data_in = 4'($urandom);
    for (int i = 0; i < 5; i++) begin
      #4;
      checkOutput("bp_in_ready_low", 32'(data_in_ready), 32'(0));
      @(negedge clock);
    end
    data_out_ready = 1'b1;
    #4;
    checkOutput("bp_in_ready_release", 32'(data_in_ready), 32'(1));
    @(negedge clock);
    data_in_valid = 1'b0;
    waitDrain("bp_drain");

    // Partial flush of chunks 1,2,3.
    applyStimulus(4'h1, 1'b0, waited);
    applyStimulus(4'h2, 1'b0, waited);
    applyStimulus(4'h3, 1'b0, waited);
    applyFlush();
    waitValid("partial_seen");
    checkOutput("partial_data", data_out, 32'h0000_0321);
    checkOutput("partial_count", 32'(data_out_count), 32'(3));
    @(negedge clock);
    sendChunks(8, "after_partial");
    waitDrain("partial_drain");

    // Flush on the 8th chunk gives one full word; flush on an empty word gives none.
    sendChunks(7, "flush8_accept");
    applyStimulus(4'($urandom), 1'b1, waited);
    waitDrain("flush8_drain");
    applyFlush();
    for (int i = 0; i < 4; i++) begin
      #4;
      checkOutput("empty_flush_no_word", 32'(data_out_valid), 32'(0));
      @(negedge clock);
    end

    // Reset with a held word and a partial word in flight: both are discarded.
    data_out_ready = 1'b0;
    sendChunks(13, "pre_reset_accept");
    nreset = 1'b0;
    repeat (2) @(negedge clock);
    nreset = 1'b1;
    checkResetState("midreset");
    data_out_ready = 1'b1;
    for (int i = 0; i < Ratio; i++) applyStimulus(4'hA, 1'b0, waited);
    waitValid("post_reset_seen");
    checkOutput("post_reset_data", data_out, 32'hAAAA_AAAA);
    checkOutput("post_reset_count", 32'(data_out_count), 32'(Ratio));
    @(negedge clock);
    waitDrain("post_reset_drain");

    // Random traffic: random valid, sink readiness and occasional flushes.
    for (int i = 0; i < 1500; i++) begin
      data_out_ready = ($urandom_range(0, 3) != 0);
      data_in_valid = $urandom_range(0, 1);
      data_in = 4'($urandom);
      flush = 1'b0;
      #1;
      if (data_in_ready && $urandom_range(0, 15) == 0) flush = 1'b1;
      @(negedge clock);
    end
    data_in_valid = 1'b0;
    flush = 1'b0;
    data_out_ready = 1'b1;
    @(negedge clock);
    applyFlush();
    waitDrain("random_drain");
    checkOutput("random_leftover_chunks", 32'(chunkQ.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/width_packer_buffer.md
WIDTH_PACKER_BUFFER -- requirements
Module: width_packer_buffer

Interface
REQ-001 SHALL have parameter input_width, default 4, narrow input chunk width in bits.
REQ-002 SHALL have parameter output_width, default 32, packed output word width; R = output_width / input_width.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port nreset  input  1  synchronous active-low reset.
REQ-006 SHALL have port data_in_valid  input  1  chunk offered this cycle.
REQ-007 SHALL have port data_in  input  input_width  chunk data.
REQ-008 SHALL have port data_in_ready  output  1  chunk accepted when valid and ready both high at rising edge.
REQ-009 SHALL have port flush  input  1  one-cycle request to emit a partial word.
REQ-010 SHALL have port data_out_valid  output  1  packed word available.
REQ-011 SHALL have port data_out  output  output_width  packed word.
REQ-012 SHALL have port data_out_count  output  $clog2(R)+1  number of valid chunks in data_out (R for a full word).
REQ-013 SHALL have port data_out_ready  input  1  word consumed when valid and ready both high at rising edge.

Function
REQ-014 SHALL pack chunks LSB-first: k-th accepted chunk of a word (k = 0..R-1) lands in data_out[k*input_width +: input_width].
REQ-015 SHALL hold an accumulator, fill count k (0..R-1), and one output register (data, count, valid).
REQ-016 SHALL define out_free = !data_out_valid or (data_out_valid and data_out_ready) in the current cycle.
REQ-017 SHALL, when the R-th chunk is accepted at edge N, drive data_out_valid high from edge N with count R, and reset k to 0 (latency 1 cycle from last chunk).
REQ-018 SHALL sustain one chunk per cycle indefinitely when data_out_ready is held high (no bubbles at word boundaries).
REQ-019 SHALL deassert data_in_ready combinationally when k == R-1 and not out_free, or when a flush is pending.
REQ-020 SHALL keep data_out, data_out_count and data_out_valid stable while data_out_valid is high and data_out_ready is low.
REQ-021 SHALL, on flush with an input chunk accepted the same cycle, include that chunk before flushing.
REQ-022 SHALL, on flush, set an internal flush_pending flag; while pending and out_free, move accumulator to output register with count k (if k > 0) and clear k and the pending flag in the same edge.
REQ-023 SHALL, on flush with k == 0 (after REQ-021), emit no word and clear pending at that edge.
REQ-024 SHALL zero all unused high bits of a partial word.
REQ-025 SHALL, if a flush completes a full word (k reaches R via REQ-021), emit exactly one word with count R, not an extra empty word.
REQ-026 SHALL ignore flush asserted while flush_pending is already set.

Reset
REQ-027 SHALL, when nreset low at a rising edge, clear k, accumulator, flush_pending, data_out_valid, data_out (0) and data_out_count (0); data_in_ready reads 1 in the cycle after reset.
REQ-028 SHALL discard any partial word and held output word on reset mid-operation, with no output produced from pre-reset chunks.

Structure
REQ-029 SHALL place no types in a shared package; count width is a local constant derived from R.
REQ-030 SHALL be a single module with no sub-modules; the elaboration shall fail if output_width is not a multiple of input_width or R < 2.

Verification
REQ-031 SHALL cover streaming: 32 random 4-bit chunks one per cycle, ready high -> 4 words, each equal to chunks concatenated LSB-first, count 8, no data_in_ready drop.
REQ-032 SHALL cover backpressure: ready low while 16 chunks offered -> word 0 held stable, data_in_ready low after 15 chunks; ready high -> both words emitted in order, no loss.
REQ-033 SHALL cover partial flush: chunks 1,2,3 then flush -> data_out 0x00000321, count 3, next word starts at bit 0.
REQ-034 SHALL cover flush coincident with 8th chunk -> one word, count 8; flush with k == 0 -> no word.
REQ-035 SHALL cover reset mid-word: 5 chunks, nreset low 2 cycles, then 8 chunks 0xA -> one word 0xAAAAAAAA, count 8.
REQ-036 SHALL pair with width_adapter_buffer (32->4) in a loopback bench: random 32-bit words, exponential gaps -> packer output equals original words bit-exact.
